// File: rtl/ram_mp_sync_if.sv
// Bus bundle for ram_mp_sync: one write port, NUM_RD read ports, and status flags.
// The memory side uses the slave modport. The requesting side uses the master modport.
interface ram_mp_sync_if #(
  parameter int D_WIDTH = 19,
  parameter int A_WIDTH = 5,
  parameter int NUM_RD  = 2
);
  // Handshake: a request (write_enable / read_enable[i]) is taken on any rising
  // edge where busy is low. There is no backpressure.
  // read_valid[i] is a one-cycle response on the edge after the request.
  // write_reject is a one-cycle response for a write that was dropped.
  logic                        write_enable;
  logic [A_WIDTH-1:0]          address_write;
  logic [D_WIDTH-1:0]          data_write;
  logic [NUM_RD-1:0]           read_enable;
  logic [NUM_RD*A_WIDTH-1:0]   address_read;
  logic [NUM_RD*D_WIDTH-1:0]   data_read;
  logic [NUM_RD-1:0]           read_valid;
  logic                        busy;
  logic                        write_reject;
  logic                        fsm_state;

  modport master (
    output write_enable, address_write, data_write, read_enable, address_read,
    input  data_read, read_valid, busy, write_reject, fsm_state
  );

  modport slave (
    input  write_enable, address_write, data_write, read_enable, address_read,
    output data_read, read_valid, busy, write_reject, fsm_state
  );
endinterface

// File: rtl/ram_mp_sync.sv
// Multi-read-port synchronous RAM with write-first bypass, registered reads,
// and a post-reset sweep that zeroes every implemented word.
module ram_mp_sync #(
  parameter int D_WIDTH        = 19,
  parameter int A_WIDTH        = 5,
  parameter int A_MAX          = 32,
  parameter int NUM_RD         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_mp_sync_if.slave   bus
);

  // The counter is one bit wider than the address so that A_MAX == 2**A_WIDTH still fits.
  localparam logic [A_WIDTH:0] LIMIT   = (A_WIDTH+1)'(A_MAX);
  localparam logic [A_WIDTH:0] LAST    = (A_WIDTH+1)'(A_MAX - 1);
  localparam logic [A_WIDTH:0] CNT_ONE = (A_WIDTH+1)'(1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t              state_q, state_d;
  logic [A_WIDTH:0]    clr_cnt_q, clr_cnt_d;
  logic [D_WIDTH-1:0]  mem [A_MAX];

  logic                mem_we;
  logic [A_WIDTH-1:0]  mem_waddr;
  logic [D_WIDTH-1:0]  mem_wdata;

  logic                busy;
  logic                wr_in_range;
  logic                wr_accept;
  logic [A_WIDTH-1:0]  rd_addr   [NUM_RD];
  logic [D_WIDTH-1:0]  rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]   rd_fire;

  logic [NUM_RD*D_WIDTH-1:0] data_read_q;
  logic [NUM_RD-1:0]         read_valid_q;
  logic                      write_reject_q;

  assign busy        = (state_q == ST_CLEAR);
  assign wr_in_range = ({1'b0, bus.address_write} < LIMIT);
  assign wr_accept   = bus.write_enable && !busy && wr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The sweep takes over the single write port. User writes only reach memory in READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = wr_accept;
    mem_waddr = bus.address_write;
    mem_wdata = bus.data_write;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[A_WIDTH-1:0];
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == LAST) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = bus.address_read[i*A_WIDTH +: A_WIDTH];
      rd_fire[i] = bus.read_enable[i] && !busy;
      if ({1'b0, rd_addr[i]} >= LIMIT)
        rd_data_d[i] = '0;
      else if (wr_accept && (bus.address_write == rd_addr[i]))
        rd_data_d[i] = bus.data_write;
      else
        rd_data_d[i] = mem[rd_addr[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_read_q    <= '0;
      read_valid_q   <= '0;
      write_reject_q <= 1'b0;
    end else begin
      write_reject_q <= bus.write_enable && (busy || !wr_in_range);
      for (int i = 0; i < NUM_RD; i++) begin
        read_valid_q[i] <= rd_fire[i];
        if (rd_fire[i]) data_read_q[i*D_WIDTH +: D_WIDTH] <= rd_data_d[i];
      end
    end
  end

  assign bus.data_read    = data_read_q;
  assign bus.read_valid   = read_valid_q;
  assign bus.busy         = busy;
  assign bus.write_reject = write_reject_q;
  assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_ram_mp_sync.sv
// Bench for ram_mp_sync: a full-depth instance (A_MAX=32) and a partial-depth instance (A_MAX=20).
// Both instances receive the same stimulus. Each instance is checked against its own array model.
module tb_ram_mp_sync;
  localparam int DW     = 19;
  localparam int AW     = 5;
  localparam int NR     = 2;
  localparam int AMAX   = 32;
  localparam int AMAX_S = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_mp_sync_if #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR)) bus_a ();
  ram_mp_sync_if #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR)) bus_b ();

  ram_mp_sync #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AMAX), .NUM_RD(NR), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  ram_mp_sync #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AMAX_S), .NUM_RD(NR), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] mem_a [AMAX];
  logic [DW-1:0] mem_b [AMAX_S];
  logic [DW-1:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                       input logic [NR-1:0] re, input logic [AW-1:0] ar0, input logic [AW-1:0] ar1);
    bus_a.write_enable = we;  bus_b.write_enable = we;
    bus_a.address_write = aw; bus_b.address_write = aw;
    bus_a.data_write = dw;    bus_b.data_write = dw;
    bus_a.read_enable = re;   bus_b.read_enable = re;
    bus_a.address_read = {ar1, ar0};
    bus_b.address_read = {ar1, ar0};
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < AMAX; i++) mem_a[i] = '0;
    for (int i = 0; i < AMAX_S; i++) mem_b[i] = '0;
  endtask

  // Counts edges after reset release until each instance drops busy.
  task automatic wait_sweep(output int na, output int nb);
    int n;
    n = 0; na = 0; nb = 0;
    while (n < 100 && (na == 0 || nb == 0)) begin
      tick();
      n++;
      if (na == 0 && !bus_a.busy) na = n;
      if (nb == 0 && !bus_b.busy) nb = n;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int na, nb;
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.busy !== 1'b1) $display("FAIL reset_busy_a: got %0b want 1", bus_a.busy); else passes++;
    checks++; if (bus_b.busy !== 1'b1) $display("FAIL reset_busy_b: got %0b want 1", bus_b.busy); else passes++;
    checks++; if (bus_a.read_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read !== '0) $display("FAIL reset_data: got %h want 0", bus_a.data_read); else passes++;
    checks++; if (bus_a.write_reject !== 1'b0) $display("FAIL reset_reject: got %0b want 0", bus_a.write_reject); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    wait_sweep(na, nb);
    checks++; if (na != AMAX) $display("FAIL sweep_len_a: got %0d want %0d", na, AMAX); else passes++;
    checks++; if (nb != AMAX_S) $display("FAIL sweep_len_b: got %0d want %0d", nb, AMAX_S); else passes++;
    model_clear();
  endtask

  task automatic test_clear_reads();
    drive(1'b0, '0, '0, 2'b11, 5'd0, 5'd17);
    tick();
    checks++; if (bus_a.read_valid !== 2'b11) $display("FAIL clr_valid: got %b want 11", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read !== '0) $display("FAIL clr_data_0_17: got %h want 0", bus_a.data_read); else passes++;
    drive(1'b0, '0, '0, 2'b01, 5'd31, 5'd0);
    tick();
    checks++; if (bus_a.read_valid !== 2'b01) $display("FAIL clr_valid31: got %b want 01", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read[DW-1:0] !== '0) $display("FAIL clr_data31: got %h want 0", bus_a.data_read[DW-1:0]); else passes++;
    idle();
    tick();
    checks++; if (bus_a.read_valid !== 2'b00) $display("FAIL valid_pulse: got %b want 00", bus_a.read_valid); else passes++;
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd3, 19'h5A5A5, 2'b00, '0, '0);
    tick();
    checks++; if (bus_a.write_reject !== 1'b0) $display("FAIL wr3_reject: got %0b want 0", bus_a.write_reject); else passes++;
    drive(1'b0, '0, '0, 2'b01, 5'd3, 5'd0);
    tick();
    checks++; if (bus_a.read_valid !== 2'b01) $display("FAIL rd3_valid: got %b want 01", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read[DW-1:0] !== 19'h5A5A5) $display("FAIL rd3_data: got %h want 5a5a5", bus_a.data_read[DW-1:0]); else passes++;
    mem_a[3] = 19'h5A5A5; mem_b[3] = 19'h5A5A5;
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd9, 19'h11111, 2'b00, '0, '0);
    tick();
    drive(1'b1, 5'd9, 19'h7FFFF, 2'b11, 5'd9, 5'd9);
    tick();
    checks++; if (bus_a.data_read !== {19'h7FFFF, 19'h7FFFF}) $display("FAIL bypass_a: got %h want both 7ffff", bus_a.data_read); else passes++;
    checks++; if (bus_b.data_read !== {19'h7FFFF, 19'h7FFFF}) $display("FAIL bypass_b: got %h want both 7ffff", bus_b.data_read); else passes++;
    drive(1'b0, '0, '0, 2'b11, 5'd9, 5'd9);
    tick();
    checks++; if (bus_a.data_read !== {19'h7FFFF, 19'h7FFFF}) $display("FAIL after_bypass: got %h want both 7ffff", bus_a.data_read); else passes++;
    idle();
    tick();
    checks++; if (bus_a.read_valid !== 2'b00) $display("FAIL hold_valid: got %b want 00", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read !== {19'h7FFFF, 19'h7FFFF}) $display("FAIL hold_data: got %h want both 7ffff", bus_a.data_read); else passes++;
    mem_a[9] = 19'h7FFFF; mem_b[9] = 19'h7FFFF;
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 5'd25, 19'h2AAAA, 2'b01, 5'd25, 5'd0);
    tick();
    checks++; if (bus_b.write_reject !== 1'b1) $display("FAIL oor_reject_b: got %0b want 1", bus_b.write_reject); else passes++;
    checks++; if (bus_a.write_reject !== 1'b0) $display("FAIL oor_reject_a: got %0b want 0", bus_a.write_reject); else passes++;
    checks++; if (bus_b.read_valid !== 2'b01) $display("FAIL oor_valid_b: got %b want 01", bus_b.read_valid); else passes++;
    checks++; if (bus_b.data_read[DW-1:0] !== '0) $display("FAIL oor_data_b: got %h want 0", bus_b.data_read[DW-1:0]); else passes++;
    checks++; if (bus_a.data_read[DW-1:0] !== 19'h2AAAA) $display("FAIL inrange_bypass_a: got %h want 2aaaa", bus_a.data_read[DW-1:0]); else passes++;
    mem_a[25] = 19'h2AAAA;
    drive(1'b0, '0, '0, 2'b10, 5'd0, 5'd9);
    tick();
    checks++; if (bus_b.write_reject !== 1'b0) $display("FAIL oor_pulse_b: got %0b want 0", bus_b.write_reject); else passes++;
    checks++; if (bus_b.data_read[2*DW-1:DW] !== 19'h7FFFF) $display("FAIL oor_nochange_b: got %h want 7ffff", bus_b.data_read[2*DW-1:DW]); else passes++;
  endtask

  task automatic test_random();
    logic          we;
    int            aw;
    int            ar [NR];
    logic [DW-1:0] dw;
    logic [NR-1:0] re;
    logic          rej_b;
    logic [DW-1:0] last_a [NR];
    logic [DW-1:0] last_b [NR];
    logic [DW-1:0] e;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      aw = $urandom_range(0, 31);
      dw = DW'($urandom);
      re = (n == 0) ? 2'b11 : NR'($urandom_range(0, 3));
      for (int p = 0; p < NR; p++) ar[p] = ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, 31);
      drive(we, AW'(aw), dw, re, AW'(ar[0]), AW'(ar[1]));
      for (int p = 0; p < NR; p++) begin
        if (re[p]) begin
          if (ar[p] >= AMAX) last_a[p] = '0;
          else if (we && aw == ar[p]) last_a[p] = dw;
          else last_a[p] = mem_a[ar[p]];
          if (ar[p] >= AMAX_S) last_b[p] = '0;
          else if (we && aw == ar[p]) last_b[p] = dw;
          else last_b[p] = mem_b[ar[p]];
        end
        exp_q.push_back(last_a[p]);
        exp_q.push_back(last_b[p]);
      end
      rej_b = we && (aw >= AMAX_S);
      if (we && aw < AMAX) mem_a[aw] = dw;
      if (we && aw < AMAX_S) mem_b[aw] = dw;
      tick();
      for (int p = 0; p < NR; p++) begin
        e = exp_q.pop_front();
        checks++; if (bus_a.data_read[p*DW +: DW] !== e) $display("FAIL rand_data_a%0d n=%0d: got %h want %h", p, n, bus_a.data_read[p*DW +: DW], e); else passes++;
        e = exp_q.pop_front();
        checks++; if (bus_b.data_read[p*DW +: DW] !== e) $display("FAIL rand_data_b%0d n=%0d: got %h want %h", p, n, bus_b.data_read[p*DW +: DW], e); else passes++;
      end
      checks++; if (bus_a.read_valid !== re) $display("FAIL rand_valid_a n=%0d: got %b want %b", n, bus_a.read_valid, re); else passes++;
      checks++; if (bus_b.read_valid !== re) $display("FAIL rand_valid_b n=%0d: got %b want %b", n, bus_b.read_valid, re); else passes++;
      checks++; if (bus_a.write_reject !== 1'b0) $display("FAIL rand_reject_a n=%0d: got %0b want 0", n, bus_a.write_reject); else passes++;
      checks++; if (bus_b.write_reject !== rej_b) $display("FAIL rand_reject_b n=%0d: got %0b want %0b", n, bus_b.write_reject, rej_b); else passes++;
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int na, nb;
    drive(1'b1, 5'd12, 19'h4C3D2, 2'b00, '0, '0);
    tick();
    drive(1'b0, '0, '0, 2'b11, 5'd12, 5'd12);
    tick();
    checks++; if (bus_a.data_read !== {19'h4C3D2, 19'h4C3D2}) $display("FAIL pre_reset_data: got %h want both 4c3d2", bus_a.data_read); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.read_valid !== 2'b00) $display("FAIL async_valid: got %b want 00", bus_a.read_valid); else passes++;
    checks++; if (bus_a.data_read !== '0) $display("FAIL async_data_a: got %h want 0", bus_a.data_read); else passes++;
    checks++; if (bus_b.data_read !== '0) $display("FAIL async_data_b: got %h want 0", bus_b.data_read); else passes++;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++; if (bus_a.busy !== 1'b1) $display("FAIL mid_sweep_busy: got %0b want 1", bus_a.busy); else passes++;
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_sweep(na, nb);
    checks++; if (na != AMAX) $display("FAIL restart_len_a: got %0d want %0d", na, AMAX); else passes++;
    checks++; if (nb != AMAX_S) $display("FAIL restart_len_b: got %0d want %0d", nb, AMAX_S); else passes++;
    model_clear();
    drive(1'b0, '0, '0, 2'b11, 5'd12, 5'd3);
    tick();
    checks++; if (bus_a.data_read !== '0) $display("FAIL restart_cleared: got %h want 0", bus_a.data_read); else passes++;
  endtask

  task automatic test_busy_reject();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
    drive(1'b1, 5'd4, 19'h12345, 2'b11, 5'd4, 5'd4);
    for (int n = 1; n <= AMAX; n++) begin
      tick();
      checks++; if (bus_a.write_reject !== 1'b1) $display("FAIL busy_reject_a n=%0d: got %0b want 1", n, bus_a.write_reject); else passes++;
      checks++; if (bus_b.write_reject !== (n <= AMAX_S)) $display("FAIL busy_reject_b n=%0d: got %0b want %0b", n, bus_b.write_reject, (n <= AMAX_S)); else passes++;
      checks++; if (bus_a.read_valid !== 2'b00) $display("FAIL busy_read_drop n=%0d: got %b want 00", n, bus_a.read_valid); else passes++;
      checks++; if (bus_b.read_valid !== ((n > AMAX_S) ? 2'b11 : 2'b00)) $display("FAIL busy_read_b n=%0d: got %b", n, bus_b.read_valid); else passes++;
      checks++; if (bus_a.busy !== (n < AMAX)) $display("FAIL busy_flag_a n=%0d: got %0b want %0b", n, bus_a.busy, (n < AMAX)); else passes++;
    end
    mem_b[4] = 19'h12345;
    idle();
    tick();
    checks++; if (bus_a.write_reject !== 1'b0) $display("FAIL reject_pulse_end: got %0b want 0", bus_a.write_reject); else passes++;
    drive(1'b0, '0, '0, 2'b11, 5'd4, 5'd4);
    tick();
    checks++; if (bus_a.data_read !== '0) $display("FAIL busy_write_dropped: got %h want 0", bus_a.data_read); else passes++;
    checks++; if (bus_b.data_read !== {mem_b[4], mem_b[4]}) $display("FAIL ready_write_b: got %h want both %h", bus_b.data_read, mem_b[4]); else passes++;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_bypass();
    test_out_of_range();
    test_random();
    test_reset_mid_sweep();
    test_busy_reject();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
